// File: rtl/micro_board_evaluator_pkg.sv
// Shared definitions for the tic-tac-toe board logic: cell/outcome codes,
// evaluator FSM encoding and the table of the eight winning lines.
package micro_board_evaluator_pkg;

  localparam int NUM_CELLS = 9;
  localparam int NUM_LINES = 8;

  typedef logic [1:0] cell_t;
  typedef logic [3:0] cell_idx_t;

  localparam cell_t EMPTY = 2'b00;
  localparam cell_t P1    = 2'b01;
  localparam cell_t P2    = 2'b10;
  localparam cell_t DRAW  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_CAPTURE,
    ST_EVAL,
    ST_WRITE
  } state_e;

  // Cell numbers are 1-based, matching the RAM address low nibble.
  localparam cell_idx_t WIN_LINES [NUM_LINES][3] = '{
    '{4'd1, 4'd2, 4'd3},
    '{4'd4, 4'd5, 4'd6},
    '{4'd7, 4'd8, 4'd9},
    '{4'd1, 4'd4, 4'd7},
    '{4'd2, 4'd5, 4'd8},
    '{4'd3, 4'd6, 4'd9},
    '{4'd1, 4'd5, 4'd9},
    '{4'd3, 4'd5, 4'd7}
  };

endpackage

// File: rtl/micro_board_evaluator_if.sv
// Request/RAM-side bundle of the micro board evaluator.
interface micro_board_evaluator_if #(
  parameter int IDX_W  = 4,
  parameter int CELL_W = 2
);
  logic                 start;
  logic [IDX_W-1:0]     macro_idx;
  logic [2*IDX_W-1:0]   micro_addr;
  logic [CELL_W-1:0]    micro_q;
  logic                 board_we;
  logic [IDX_W-1:0]     board_addr;
  logic [CELL_W-1:0]    board_data;
  logic [CELL_W-1:0]    result;
  logic                 busy;
  logic                 done;

  // master: controller plus both RAMs as seen from outside the evaluator
  modport master (
    output start, macro_idx, micro_q,
    input  micro_addr, board_we, board_addr, board_data, result, busy, done
  );

  modport slave (
    input  start, macro_idx, micro_q,
    output micro_addr, board_we, board_addr, board_data, result, busy, done
  );
endinterface

// File: rtl/micro_board_evaluator_tris_eval.sv
// Combinational 3x3 board judge: line win (P1 priority), full-board draw, else ongoing.
module tris_eval
  import micro_board_evaluator_pkg::*;
#(
  parameter bit REPORT_DRAW = 1'b1
) (
  input  cell_t [NUM_CELLS:1] cells,
  output cell_t               outcome
);

  logic [NUM_LINES-1:0] p1_line;
  logic [NUM_LINES-1:0] p2_line;
  logic [NUM_CELLS:1]   filled;

  for (genvar l = 0; l < NUM_LINES; l++) begin : g_line
    assign p1_line[l] = (cells[WIN_LINES[l][0]] == P1) &&
                        (cells[WIN_LINES[l][1]] == P1) &&
                        (cells[WIN_LINES[l][2]] == P1);
    assign p2_line[l] = (cells[WIN_LINES[l][0]] == P2) &&
                        (cells[WIN_LINES[l][1]] == P2) &&
                        (cells[WIN_LINES[l][2]] == P2);
  end

  // Code 11 fills a cell but can never complete a line.
  for (genvar c = 1; c <= NUM_CELLS; c++) begin : g_cell
    assign filled[c] = (cells[c] != EMPTY);
  end

  always_comb begin
    outcome = EMPTY;
    if (|p1_line)                     outcome = P1;
    else if (|p2_line)                outcome = P2;
    else if (REPORT_DRAW && &filled)  outcome = DRAW;
  end

endmodule

// File: rtl/micro_board_evaluator.sv
// Scans one micro board from the micro-cell RAM after a move and writes the
// resulting outcome into the macro board RAM.
module micro_board_evaluator
  import micro_board_evaluator_pkg::*;
#(
  parameter int IDX_W      = 4,
  parameter int CELL_W     = 2,
  parameter bit WRITE_DRAW = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  micro_board_evaluator_if.slave  bus
);

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [2*IDX_W-1:0]    micro_addr_q, micro_addr_d;
  cell_t [NUM_CELLS:1]   cells_q, cells_d;
  logic [CELL_W-1:0]     result_q, result_d;
  logic [IDX_W-1:0]      board_addr_q, board_addr_d;
  logic [CELL_W-1:0]     board_data_q, board_data_d;
  logic                  board_we_q, board_we_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  cell_t                 outcome;
  logic                  idx_ok;
  logic [IDX_W-1:0]      cnt_inc;

  tris_eval #(.REPORT_DRAW(WRITE_DRAW)) u_eval (
    .cells   (cells_q),
    .outcome (outcome)
  );

  assign idx_ok  = (bus.macro_idx != '0) && (bus.macro_idx <= IDX_W'(NUM_CELLS));
  assign cnt_inc = cnt_q + IDX_W'(1);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    micro_addr_d = micro_addr_q;
    cells_d      = cells_q;
    result_d     = result_q;
    board_addr_d = board_addr_q;
    board_data_d = board_data_q;
    board_we_d   = 1'b0;
    done_d       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start && idx_ok) begin
          state_d      = ST_READ;
          idx_d        = bus.macro_idx;
          cnt_d        = IDX_W'(1);
          micro_addr_d = {bus.macro_idx, IDX_W'(1)};
        end
      end
      ST_READ: begin
        // RAM data trails the address by one cycle: this cycle's micro_q is cell cnt-1.
        if (cnt_q != IDX_W'(1)) cells_d[cnt_q - IDX_W'(1)] = bus.micro_q;
        if (cnt_q == IDX_W'(NUM_CELLS)) begin
          state_d = ST_CAPTURE;
        end else begin
          cnt_d        = cnt_inc;
          micro_addr_d = {idx_q, cnt_inc};
        end
      end
      ST_CAPTURE: begin
        cells_d[NUM_CELLS] = bus.micro_q;
        state_d            = ST_EVAL;
      end
      ST_EVAL: begin
        result_d     = outcome;
        board_addr_d = idx_q;
        board_data_d = outcome;
        board_we_d   = (outcome != EMPTY);
        done_d       = 1'b1;
        state_d      = ST_WRITE;
      end
      ST_WRITE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      micro_addr_q <= '0;
      cells_q      <= '0;
      result_q     <= '0;
      board_addr_q <= '0;
      board_data_q <= '0;
      board_we_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      micro_addr_q <= micro_addr_d;
      cells_q      <= cells_d;
      result_q     <= result_d;
      board_addr_q <= board_addr_d;
      board_data_q <= board_data_d;
      board_we_q   <= board_we_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign bus.micro_addr = micro_addr_q;
  assign bus.board_we   = board_we_q;
  assign bus.board_addr = board_addr_q;
  assign bus.board_data = board_data_q;
  assign bus.result     = result_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_micro_board_evaluator.sv
// Directed bench: micro RAM model with registered read, hand-computed outcomes.
module tb_micro_board_evaluator;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  micro_board_evaluator_if #(.IDX_W(4), .CELL_W(2)) if1 ();
  micro_board_evaluator_if #(.IDX_W(4), .CELL_W(2)) if0 ();

  micro_board_evaluator #(.IDX_W(4), .CELL_W(2), .WRITE_DRAW(1'b1)) dut1 (
    .clk(clk), .reset_n(rst_n), .bus(if1));
  micro_board_evaluator #(.IDX_W(4), .CELL_W(2), .WRITE_DRAW(1'b0)) dut0 (
    .clk(clk), .reset_n(rst_n), .bus(if0));

  logic [1:0] mem [256];
  always @(posedge clk) begin
    if1.micro_q <= mem[if1.micro_addr];
    if0.micro_q <= mem[if0.micro_addr];
  end

  int n_chk = 0;
  int n_err = 0;
  int ndone1 = 0;
  int nwe1 = 0;
  always @(posedge clk) begin
    if (if1.done)     ndone1 <= ndone1 + 1;
    if (if1.board_we) nwe1   <= nwe1 + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // s holds cells 1..9 as digits 0..3
  task automatic load(input logic [3:0] idx, input string s);
    for (int k = 1; k <= 9; k++) mem[{idx, 4'(k)}] = 2'(s.getc(k - 1) - 8'd48);
  endtask

  task automatic run_main(input string tag, input logic [3:0] idx, input string s,
                          input logic [1:0] exp, input bit poke);
    load(idx, s);
    if1.start = 1'b1; if1.macro_idx = idx;
    tick;
    if1.start = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      chk({tag, "_addr"}, if1.micro_addr, {idx, 4'(k)});
      chk({tag, "_busy"}, if1.busy, 1);
      if (poke && k == 3) begin if1.start = 1'b1; if1.macro_idx = 4'd8; end
      if (poke && k == 4) if1.start = 1'b0;
      tick;
    end
    tick;
    chk({tag, "_done11"}, if1.done, 0);
    tick;
    chk({tag, "_done"}, if1.done, 1);
    chk({tag, "_we"}, if1.board_we, (exp != 2'b00));
    chk({tag, "_result"}, if1.result, exp);
    if (exp != 2'b00) begin
      chk({tag, "_baddr"}, if1.board_addr, idx);
      chk({tag, "_bdata"}, if1.board_data, exp);
    end
    if (poke) begin if1.start = 1'b1; if1.macro_idx = 4'd8; end
    tick;
    if1.start = 1'b0;
    chk({tag, "_busy13"}, if1.busy, 0);
    chk({tag, "_done13"}, if1.done, 0);
    chk({tag, "_we13"}, if1.board_we, 0);
    chk({tag, "_hold"}, if1.result, exp);
  endtask

  task automatic bad_start(input string tag, input logic [3:0] idx);
    int d0;
    d0 = ndone1;
    if1.start = 1'b1; if1.macro_idx = idx;
    tick;
    if1.start = 1'b0;
    chk({tag, "_busy"}, if1.busy, 0);
    repeat (14) tick;
    chk({tag, "_ndone"}, ndone1, d0);
  endtask

  initial begin
    int d0, w0;
    for (int i = 0; i < 256; i++) mem[i] = 2'b00;
    if1.start = 1'b0; if1.macro_idx = '0;
    if0.start = 1'b0; if0.macro_idx = '0;
    #1;
    chk("rst_addr", if1.micro_addr, 0);
    chk("rst_we", if1.board_we, 0);
    chk("rst_result", if1.result, 0);
    chk("rst_busy", if1.busy, 0);
    chk("rst_done", if1.done, 0);
    tick; tick;
    rst_n = 1'b1;
    tick;

    run_main("p1row", 4'd3, "111000000", 2'b01, 1'b0);

    // reset while cnt=5 aborts the scan with no write
    w0 = nwe1; d0 = ndone1;
    load(4'd5, "111000000");
    if1.start = 1'b1; if1.macro_idx = 4'd5;
    tick;
    if1.start = 1'b0;
    repeat (4) tick;
    chk("mid_addr_pre", if1.micro_addr, 8'h55);
    rst_n = 1'b0;
    #1;
    chk("mid_addr", if1.micro_addr, 0);
    chk("mid_busy", if1.busy, 0);
    chk("mid_result", if1.result, 0);
    chk("mid_baddr", if1.board_addr, 0);
    chk("mid_bdata", if1.board_data, 0);
    tick;
    rst_n = 1'b1;
    repeat (15) tick;
    chk("mid_nwe", nwe1, w0);
    chk("mid_ndone", ndone1, d0);

    run_main("p2diag", 4'd7, "112020200", 2'b10, 1'b0);
    run_main("draw", 4'd5, "121122211", 2'b11, 1'b0);
    run_main("open4", 4'd1, "121210000", 2'b00, 1'b0);
    run_main("both", 4'd9, "111000222", 2'b01, 1'b0);
    run_main("all11", 4'd2, "333333333", 2'b11, 1'b0);

    // redundant starts ignored, then back-to-back accept in cycle 13
    d0 = ndone1;
    run_main("p2col", 4'd4, "121020020", 2'b10, 1'b1);
    run_main("b2b", 4'd6, "100110001", 2'b01, 1'b0);
    chk("b2b_ndone", ndone1, d0 + 2);

    bad_start("idx0", 4'd0);
    bad_start("idx10", 4'd10);

    // draw reported as ongoing when draws are not written
    load(4'd5, "121122211");
    if0.start = 1'b1; if0.macro_idx = 4'd5;
    tick;
    if0.start = 1'b0;
    repeat (11) tick;
    chk("nodraw_done", if0.done, 1);
    chk("nodraw_we", if0.board_we, 0);
    chk("nodraw_result", if0.result, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/micro_board_evaluator.md
Name: micro_board_evaluator

Overview:
- Upstream stage of the macro board-state RAM; evaluates one 3x3 micro board after a move and writes its outcome into the macro RAM.
- The control FSM pulses start with the macro cell index just played.
- The block scans the 9 micro cells from the micro-cell RAM, which has 1-cycle registered-address read latency.
- It decides win/draw/ongoing and issues a single-cycle write (we/addr/data) to the macro RAM.

Parameters:
- IDX_W, 4, width of macro/micro cell index (cells 1..9 used, 0 unused).
- CELL_W, 2, width of a cell code.
- WRITE_DRAW, 1, if 1 a draw (11) is written to the macro RAM; if 0 a draw is treated as ongoing (no write).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- macro_idx  in  IDX_W  macro cell to evaluate (1..9); sampled with start.
- micro_addr  out  2*IDX_W  micro RAM read address = {macro_idx_reg, cell}.
- micro_q  in  CELL_W  micro RAM read data, valid one cycle after micro_addr.
- board_we  out  1  write enable to macro RAM.
- board_addr  out  IDX_W  macro RAM address (= latched macro_idx).
- board_data  out  CELL_W  outcome: 00 ongoing, 01 P1, 10 P2, 11 draw.
- result  out  CELL_W  registered last outcome, held until the next evaluation completes.
- busy  out  1  high from the cycle after start is accepted through the WRITE cycle.
- done  out  1  one-cycle pulse in the WRITE cycle.

Behaviour:
- Reset (async, reset_n=0): state IDLE; micro_addr=0, board_we=0, board_addr=0, board_data=0, result=00, busy=0, done=0; shadow cell regs cleared to 00. Reset mid-scan aborts with no write.
- Cell codes: 00 empty, 01 P1, 10 P2. Code 11 is treated as occupied by nobody: it counts toward a full board but never toward a line.
- FSM states: IDLE, READ, CAPTURE, EVAL, WRITE.
- IDLE: on edge E0 with start=1, latch macro_idx; go to READ, cnt=1.
- start while busy: ignored, not queued.
- macro_idx of 0 or above 9: start ignored, stay IDLE.
- READ, cycles 1..9: micro_addr={macro_idx_reg, cnt}. At edge E(k+1), micro_q is stored as shadow cell k (k=1..8). After cycle 9, go to CAPTURE.
- CAPTURE, cycle 10: micro_addr holds cell 9; store micro_q as cell 9.
- EVAL, cycle 11: combinational evaluation registered into result at E11.
  - Lines checked: rows 123/456/789, columns 147/258/369, diagonals 159/357.
  - Any P1 line gives 01. Else any P2 line gives 10.
  - Both players having a line (illegal position) gives 01 (P1 priority).
  - Else all nine cells non-00 gives 11, or 00 if WRITE_DRAW=0.
  - Else 00.
- WRITE, cycle 12: done=1. board_we=1 only if result!=00, with board_addr=macro_idx_reg and board_data=result. Return to IDLE at E12.
- Latency: start accepted at E0 to done at cycle 12. The next start is accepted in cycle 13 at the earliest.
- board_addr/board_data are held at their last values outside WRITE. board_we and done are 0 outside WRITE.
- The block never reads the macro RAM. The controller must not start evaluation of a macro cell already decided. The block itself does not guard against this.

Decomposition:
- Shared package (used also by the macro RAM and controller):
  - cell/outcome code constants: EMPTY=00, P1=01, P2=10, DRAW=11.
  - FSM state encoding.
  - 8-entry win-line index table.
  - NUM_CELLS=9.
- Sub-module tris_eval: purely combinational, 9x2-bit cells in, 2-bit outcome out, encodes the line/draw rules above. Reusable by the macro-board logic.
- micro_board_evaluator holds the FSM, counter, shadow registers and output registers.

Test Plan:
- Reset mid-scan: reset_n low during READ cnt=5 -> all outputs 0 immediately, state IDLE, no board_we afterwards.
- P1 row: macro 3, cells 1,2,3=01, rest 00, start -> micro_addr 0x31..0x39 in cycles 1-9; cycle 12 board_we=1, board_addr=3, board_data=01, done=1, result=01.
- P2 diagonal: macro 7, cells 3,5,7=10, cells 1,2=01 -> cycle 12 board_data=10, board_we=1.
- Draw and ongoing:
  - full board, no line -> board_data=11, board_we=1.
  - same with WRITE_DRAW=0 -> board_we=0, done=1, result=00.
  - board with 4 empties, no line -> board_we=0, done=1.
- Start handling:
  - start re-asserted in cycles 3 and 12 -> ignored; exactly one done.
  - start in cycle 13 -> accepted, second done in cycle 25.
  - start with macro_idx=0 or 10 -> busy stays 0, no done.
- Illegal/invalid codes:
  - cells 1,2,3=01 and 7,8,9=10 -> board_data=01.
  - all cells 11 -> board_data=11 (draw, no win).
